// File: rtl/util_bfp_scaler.sv
// Block-floating-point to fixed-point scaler: two-stage valid/ready pipeline with per-packet statistics.
// Define UTIL_BFP_SCALER_SAT_EN to saturate overflowing lanes; otherwise they wrap.

module util_bfp_scaler_lane #(
  parameter int SW           = 42,
  parameter int OUTPUT_WIDTH = 16,
  parameter int OUT_LSB      = 4
) (
  input  logic [SW-1:0]           shifted,
  input  logic                    invalid,
  output logic [OUTPUT_WIDTH-1:0] data,
  output logic                    ovf,
  output logic                    udf
);
  localparam int MSB = OUT_LSB + OUTPUT_WIDTH - 1;

  logic [SW-1-MSB:0] top;
  logic              ovf_raw;
  logic              udf_raw;

  // Output MSB plus everything above it must be pure sign extension.
  assign top     = shifted[SW-1:MSB];
  assign ovf_raw = ~((&top) | ~(|top));

  generate
    if (OUT_LSB > 0) begin : g_udf
      assign udf_raw = |shifted[OUT_LSB-1:0];
    end else begin : g_no_udf
      assign udf_raw = 1'b0;
    end
  endgenerate

`ifdef UTIL_BFP_SCALER_SAT_EN
  assign data = !ovf_raw      ? shifted[MSB:OUT_LSB] :
                shifted[SW-1] ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}} :
                                {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
`else
  assign data = shifted[MSB:OUT_LSB];
`endif

  assign ovf = ovf_raw | invalid;
  assign udf = udf_raw | invalid;
endmodule

module util_bfp_scaler #(
  parameter int LANES        = 2,
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 16,
  parameter int EXP_REF      = 4,
  parameter int MAX_SHIFT    = 25,
  parameter int OUT_LSB      = 4,
  parameter int EXP_MODE     = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            din_valid,
  output logic                            din_ready,
  input  logic                            din_sop,
  input  logic                            din_eop,
  input  logic [LANES*INPUT_WIDTH-1:0]    din_data,
  input  logic [5:0]                      din_exp,
  input  logic [1:0]                      din_error,
  output logic                            dout_valid,
  input  logic                            dout_ready,
  output logic                            dout_sop,
  output logic                            dout_eop,
  output logic [1:0]                      dout_error,
  output logic [LANES*OUTPUT_WIDTH-1:0]   dout_data,
  output logic [LANES-1:0]                dout_overflow,
  output logic [LANES-1:0]                dout_underflow,
  output logic [5:0]                      dout_resolution,
  output logic                            dout_exp_invalid,
  output logic                            stat_valid,
  output logic [15:0]                     stat_ovf_cnt,
  output logic [15:0]                     stat_udf_cnt,
  output logic [5:0]                      stat_min_res
);
  localparam int SW      = INPUT_WIDTH + MAX_SHIFT + 1;
  localparam int RES_RST = (INPUT_WIDTH < OUTPUT_WIDTH) ? INPUT_WIDTH : OUTPUT_WIDTH;
  localparam int OMSB    = OUT_LSB + OUTPUT_WIDTH - 1;

  logic en, in_acc, out_acc;
  assign en        = dout_ready | ~dout_valid;
  assign din_ready = en;
  assign in_acc    = din_valid & en;
  assign out_acc   = dout_valid & dout_ready;

  // Exponent latched per packet (EXP_MODE=1); the SOP beat itself uses din_exp directly.
  logic [5:0] exp_q, eff_exp;
  always_ff @(posedge clk) begin
    if (rst)                  exp_q <= 6'(EXP_REF);
    else if (in_acc & din_sop) exp_q <= din_exp;
  end
  assign eff_exp = (EXP_MODE != 0 && !din_sop) ? exp_q : din_exp;

  int         sh_i, res_hi, res_lo, res_r;
  logic       sh_ok;
  logic [5:0] sh_amt, res_d;
  always_comb begin
    sh_i   = EXP_REF - int'($signed(eff_exp));
    sh_ok  = (sh_i >= 0) && (sh_i <= MAX_SHIFT);
    sh_amt = 6'(sh_i);
    res_hi = (sh_i + INPUT_WIDTH - 1 < OMSB) ? sh_i + INPUT_WIDTH - 1 : OMSB;
    res_lo = (sh_i > OUT_LSB) ? sh_i : OUT_LSB;
    res_r  = res_hi - res_lo + 1;
    res_d  = (sh_ok && res_r > 0) ? 6'(res_r) : 6'd0;
  end

  logic [LANES-1:0][SW-1:0] shf_d, s1_shf;
  for (genvar k = 0; k < LANES; k++) begin : g_shift
    logic [INPUT_WIDTH-1:0] x;
    assign x        = din_data[k*INPUT_WIDTH +: INPUT_WIDTH];
    assign shf_d[k] = sh_ok ? ({{(SW-INPUT_WIDTH){x[INPUT_WIDTH-1]}}, x} << sh_amt) : '0;
  end

  logic       s1_valid, s1_sop, s1_eop, s1_inv;
  logic [1:0] s1_err;
  logic [5:0] s1_res;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sop   <= 1'b0;
      s1_eop   <= 1'b0;
      s1_inv   <= 1'b0;
      s1_err   <= '0;
      s1_res   <= '0;
      s1_shf   <= '0;
    end else if (en) begin
      s1_valid <= din_valid;
      s1_sop   <= din_sop;
      s1_eop   <= din_eop;
      s1_inv   <= ~sh_ok;
      s1_err   <= din_error;
      s1_res   <= res_d;
      s1_shf   <= shf_d;
    end
  end

  logic [LANES-1:0][OUTPUT_WIDTH-1:0] lane_d;
  logic [LANES-1:0]                   ovf_d, udf_d;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    util_bfp_scaler_lane #(.SW(SW), .OUTPUT_WIDTH(OUTPUT_WIDTH), .OUT_LSB(OUT_LSB)) u_lane (
      .shifted (s1_shf[k]),
      .invalid (s1_inv),
      .data    (lane_d[k]),
      .ovf     (ovf_d[k]),
      .udf     (udf_d[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid       <= 1'b0;
      dout_sop         <= 1'b0;
      dout_eop         <= 1'b0;
      dout_error       <= '0;
      dout_data        <= '0;
      dout_overflow    <= '0;
      dout_underflow   <= '0;
      dout_exp_invalid <= 1'b0;
      dout_resolution  <= 6'(RES_RST);
    end else if (en) begin
      dout_valid       <= s1_valid;
      dout_sop         <= s1_sop;
      dout_eop         <= s1_eop;
      dout_error       <= s1_err;
      dout_data        <= lane_d;
      dout_overflow    <= ovf_d;
      dout_underflow   <= udf_d;
      dout_exp_invalid <= s1_inv;
      dout_resolution  <= s1_res;
    end
  end

  // Running packet statistics; SOP reloads so the SOP beat is counted from scratch.
  logic [15:0] acc_ovf, acc_udf, cur_ovf, cur_udf;
  logic [5:0]  acc_min, cur_min;
  logic        any_ovf, any_udf;
  assign any_ovf = |dout_overflow;
  assign any_udf = |dout_underflow;

  always_comb begin
    cur_ovf = dout_sop ? 16'(any_ovf) : (acc_ovf == 16'hFFFF) ? acc_ovf : acc_ovf + 16'(any_ovf);
    cur_udf = dout_sop ? 16'(any_udf) : (acc_udf == 16'hFFFF) ? acc_udf : acc_udf + 16'(any_udf);
    cur_min = (dout_sop || dout_resolution < acc_min) ? dout_resolution : acc_min;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_ovf      <= '0;
      acc_udf      <= '0;
      acc_min      <= 6'd63;
      stat_valid   <= 1'b0;
      stat_ovf_cnt <= '0;
      stat_udf_cnt <= '0;
      stat_min_res <= 6'd63;
    end else begin
      stat_valid <= out_acc & dout_eop;
      if (out_acc) begin
        acc_ovf <= cur_ovf;
        acc_udf <= cur_udf;
        acc_min <= cur_min;
        if (dout_eop) begin
          stat_ovf_cnt <= cur_ovf;
          stat_udf_cnt <= cur_udf;
          stat_min_res <= cur_min;
        end
      end
    end
  end
endmodule

// File: tb/tb_util_bfp_scaler.sv
// Directed + randomized-backpressure bench for util_bfp_scaler (default parameters).
module tb_util_bfp_scaler;
  logic        clk = 0;
  logic        rst;
  logic        din_valid, din_ready, din_sop, din_eop;
  logic [31:0] din_data;
  logic [5:0]  din_exp;
  logic [1:0]  din_error;
  logic        dout_valid, dout_ready, dout_sop, dout_eop;
  logic [1:0]  dout_error;
  logic [31:0] dout_data;
  logic [1:0]  dout_overflow, dout_underflow;
  logic [5:0]  dout_resolution;
  logic        dout_exp_invalid;
  logic        stat_valid;
  logic [15:0] stat_ovf_cnt, stat_udf_cnt;
  logic [5:0]  stat_min_res;

  util_bfp_scaler dut (
    .clk(clk), .rst(rst),
    .din_valid(din_valid), .din_ready(din_ready), .din_sop(din_sop), .din_eop(din_eop),
    .din_data(din_data), .din_exp(din_exp), .din_error(din_error),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_sop(dout_sop), .dout_eop(dout_eop),
    .dout_error(dout_error), .dout_data(dout_data), .dout_overflow(dout_overflow),
    .dout_underflow(dout_underflow), .dout_resolution(dout_resolution),
    .dout_exp_invalid(dout_exp_invalid), .stat_valid(stat_valid),
    .stat_ovf_cnt(stat_ovf_cnt), .stat_udf_cnt(stat_udf_cnt), .stat_min_res(stat_min_res)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; logic [5:0] e; logic sop; logic eop; logic [1:0] err; } beat_t;

  int n_chk = 0, n_fail = 0;
  int n_sent = 0, n_got = 0;
  logic [46:0] exp_q[$];
  beat_t       stim[$];
  logic [5:0]  m_exp = 6'd4;
  bit          mon_en = 0, rnd_rdy = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: value * 2^shift, then truncate to the output window.
  function automatic logic [46:0] model(input logic [31:0] d, input logic [5:0] e,
                                        input logic sop, input logic eop, input logic [1:0] err);
    logic [31:0] od;
    logic [1:0]  ov, ud;
    logic [5:0]  res;
    int          sh, hi, lo, r;
    longint      v, q;
    sh = 4 - int'($signed(e));
    if (sh < 0 || sh > 25) return {32'h0, 2'b11, 2'b11, 6'd0, sop, eop, 1'b1, err};
    for (int k = 0; k < 2; k++) begin
      v = longint'($signed(d[k*16 +: 16])) * (longint'(1) << sh);
      q = v >>> 4;
      ov[k] = (q > 32767) || (q < -32768);
      ud[k] = (v % 16) != 0;
      od[k*16 +: 16] = q[15:0];
`ifdef UTIL_BFP_SCALER_SAT_EN
      if (ov[k]) od[k*16 +: 16] = (v < 0) ? 16'h8000 : 16'h7FFF;
`endif
    end
    hi  = (sh + 15 < 19) ? sh + 15 : 19;
    lo  = (sh > 4) ? sh : 4;
    r   = hi - lo + 1;
    res = (r > 0) ? 6'(r) : 6'd0;
    return {od, ov, ud, res, sop, eop, 1'b0, err};
  endfunction

  // Ready toggler for backpressure phases.
  initial forever begin
    @(posedge clk); #1;
    if (rnd_rdy) dout_ready = ($urandom_range(0, 99) < 60);
  end

  // Output monitor: ordering, stall stability and packet statistics.
  logic [46:0] held_vec, e_vec;
  bit          held = 0, st_pend = 0;
  logic [15:0] m_so, m_su;
  logic [5:0]  m_sm;
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (st_pend) begin
        chk("stat_pulse", stat_valid, 1);
        chk("stat_vals", {stat_ovf_cnt, stat_udf_cnt, stat_min_res}, {m_so, m_su, m_sm});
        st_pend = 0;
      end else if (stat_valid) chk("stat_spurious", stat_valid, 0);
      if (held) chk("stall_hold", {dout_data, dout_overflow, dout_underflow, dout_resolution,
                                   dout_sop, dout_eop, dout_exp_invalid, dout_error}, held_vec);
      held     = dout_valid && !dout_ready;
      held_vec = {dout_data, dout_overflow, dout_underflow, dout_resolution,
                  dout_sop, dout_eop, dout_exp_invalid, dout_error};
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", dout_valid, 0);
        else begin
          e_vec = exp_q.pop_front();
          n_got++;
          chk("beat", held_vec, e_vec);
          if (e_vec[4]) begin
            m_so = 16'(|e_vec[14:13]); m_su = 16'(|e_vec[12:11]); m_sm = e_vec[10:5];
          end else begin
            if (|e_vec[14:13] && m_so != 16'hFFFF) m_so++;
            if (|e_vec[12:11] && m_su != 16'hFFFF) m_su++;
            if (e_vec[10:5] < m_sm) m_sm = e_vec[10:5];
          end
          if (e_vec[3]) st_pend = 1;
        end
      end
    end else begin
      held = 0; st_pend = 0;
    end
  end

  task automatic send_beat(input beat_t b);
    int t = 0;
    bit acc = 0;
    din_valid = 1; din_data = b.d; din_exp = b.e; din_sop = b.sop; din_eop = b.eop; din_error = b.err;
    while (!acc && t < 1000) begin
      @(negedge clk); acc = din_ready;
      @(posedge clk); #1; t++;
    end
    if (!acc) chk("send_timeout", t, 0);
    else begin
      if (b.sop) m_exp = b.e;
      exp_q.push_back(model(b.d, b.sop ? b.e : m_exp, b.sop, b.eop, b.err));
      n_sent++;
    end
    din_valid = 0;
  endtask

  task automatic run_stream(input bit gaps);
    int t = 0;
    foreach (stim[i]) begin
      send_beat(stim[i]);
      if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end
    while (exp_q.size() != 0 && t < 2000) begin @(posedge clk); #1; t++; end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic beat_check(input string tag, input logic [5:0] e, input logic [31:0] d,
                            input logic [1:0] err, input logic [31:0] xd, input logic [1:0] xo,
                            input logic [1:0] xu, input logic [5:0] xr, input logic xi);
    din_valid = 1; din_data = d; din_exp = e; din_sop = 1; din_eop = 1; din_error = err;
    @(posedge clk); #1; din_valid = 0;
    chk({tag, "_lat1"}, dout_valid, 0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, dout_valid, 1);
    chk({tag, "_data"}, dout_data, xd);
    chk({tag, "_flags"}, {dout_overflow, dout_underflow, dout_exp_invalid, dout_sop, dout_eop, dout_error},
        {xo, xu, xi, 1'b1, 1'b1, err});
    chk({tag, "_res"}, dout_resolution, xr);
    @(posedge clk); #1;
    chk({tag, "_stat"}, {stat_valid, stat_ovf_cnt, stat_udf_cnt, stat_min_res},
        {1'b1, 16'(|xo), 16'(|xu), xr});
    @(posedge clk); #1;
    chk({tag, "_idle"}, {stat_valid, dout_valid}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t b;
    int    rem, len;
    rst = 1; din_valid = 0; din_sop = 0; din_eop = 0; din_data = 0; din_exp = 0; din_error = 0;
    dout_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout_data", dout_data, 0);
    chk("rst_flags", {dout_sop, dout_eop, dout_error, dout_overflow, dout_underflow, dout_exp_invalid}, 0);
    chk("rst_res", dout_resolution, 16);
    chk("rst_stat", {stat_valid, stat_ovf_cnt, stat_udf_cnt, stat_min_res}, {1'b0, 32'h0, 6'd63});
    chk("rst_din_ready", din_ready, 1);

    beat_check("exp0",  6'h00, 32'hFFF0_1234, 2'b10, 32'hFFF0_1234, 2'b00, 2'b00, 6'd16, 1'b0);
    beat_check("exp4",  6'h04, 32'hFFF0_1234, 2'b01, 32'hFFFF_0123, 2'b00, 2'b01, 6'd12, 1'b0);
`ifdef UTIL_BFP_SCALER_SAT_EN
    beat_check("expm3", 6'h3D, 32'hFFF0_1234, 2'b00, 32'hFF80_7FFF, 2'b01, 2'b00, 6'd13, 1'b0);
    beat_check("sh25",  6'h2B, 32'h0001_0000, 2'b00, 32'h7FFF_0000, 2'b10, 2'b00, 6'd0,  1'b0);
`else
    beat_check("expm3", 6'h3D, 32'hFFF0_1234, 2'b00, 32'hFF80_91A0, 2'b01, 2'b00, 6'd13, 1'b0);
    beat_check("sh25",  6'h2B, 32'h0001_0000, 2'b00, 32'h0000_0000, 2'b10, 2'b00, 6'd0,  1'b0);
`endif
    beat_check("exp5",  6'h05, 32'hFFF0_1234, 2'b11, 32'h0000_0000, 2'b11, 2'b11, 6'd0,  1'b1);
    beat_check("sh26",  6'h2A, 32'h0001_0000, 2'b00, 32'h0000_0000, 2'b11, 2'b11, 6'd0,  1'b1);

    // Latched exponent: later beats carry exp=-3 but must scale by the SOP exponent 0.
    mon_en = 1;
    stim.delete();
    for (int i = 0; i < 4; i++) begin
      b.d = 32'hFFF0_1234; b.e = (i == 0) ? 6'h00 : 6'h3D; b.sop = (i == 0); b.eop = (i == 3); b.err = 0;
      stim.push_back(b);
    end
    run_stream(0);
    repeat (3) begin @(posedge clk); #1; end
    chk("pkt_stat_ovf", stat_ovf_cnt, 0);
    chk("pkt_stat_min", stat_min_res, 16);

    // Random packets under random backpressure.
    stim.delete();
    rem = 100;
    while (rem > 0) begin
      len = $urandom_range(1, 8);
      if (len > rem) len = rem;
      for (int i = 0; i < len; i++) begin
        b.d = $urandom; b.e = 6'(int'($urandom_range(0, 31)) - 25);
        b.sop = (i == 0); b.eop = (i == len - 1); b.err = 2'($urandom_range(0, 3));
        stim.push_back(b);
      end
      rem -= len;
    end
    rnd_rdy = 1;
    run_stream(1);
    rnd_rdy = 0; dout_ready = 1;
    repeat (3) begin @(posedge clk); #1; end
    mon_en = 0;
    chk("beat_count", n_got, n_sent);

    // Reset with a stalled beat in flight: it is dropped and no stat pulse follows.
    dout_ready = 0;
    din_valid = 1; din_sop = 1; din_eop = 0; din_exp = 6'h00; din_data = 32'h0001_0001;
    @(posedge clk); #1; din_valid = 0;
    repeat (2) begin @(posedge clk); #1; end
    chk("stall_valid", dout_valid, 1);
    rst = 1;
    @(posedge clk); #1; rst = 0;
    chk("midrst_valid", dout_valid, 0);
    chk("midrst_stat", {stat_valid, stat_min_res}, {1'b0, 6'd63});
    dout_ready = 1;
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst_nopulse", {stat_valid, dout_valid}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/util_bfp_scaler.md
# util_bfp_scaler

Multi-lane block-floating-point to fixed-point scaler with a full valid/ready pipeline, an exponent that is either per-beat or latched per packet, and per-packet resolution/overflow statistics. It sits between a block-floating-point FFT/IFFT and the fixed-point TX datapath. It replaces per-sample ad-hoc scaling with a backpressure-correct, multi-channel stage.

## Interface
- LANES, 2: number of parallel signed lanes (e.g. real/imag) per beat
- INPUT_WIDTH, 16: bits per input lane
- OUTPUT_WIDTH, 16: bits per output lane
- EXP_REF, 4: exponent giving zero left shift; shift = EXP_REF − din_exp
- MAX_SHIFT, 25: largest legal shift; legal shift range is 0..MAX_SHIFT
- OUT_LSB, 4: bit index of the shifted value taken as output LSB
- EXP_MODE, 1: 0 = exponent sampled every beat; 1 = exponent latched on SOP beat, ignored on other beats
- clk  in  1  clock, posedge
- rst  in  1  synchronous reset, active-high
- din_valid / din_ready  in / out  1 / 1  input handshake
- din_sop, din_eop  in  1 each  packet delimiters
- din_data  in  LANES*INPUT_WIDTH  lane k at [k*INPUT_WIDTH +: INPUT_WIDTH]
- din_exp  in  6  signed exponent
- din_error  in  2  passed through
- dout_valid / dout_ready  out / in  1 / 1  output handshake
- dout_sop, dout_eop, dout_error  out  1, 1, 2  delayed copies
- dout_data  out  LANES*OUTPUT_WIDTH  scaled lanes
- dout_overflow, dout_underflow  out  LANES each  per-lane precision loss flags
- dout_resolution  out  6  effective output bits for this beat
- dout_exp_invalid  out  1  shift outside 0..MAX_SHIFT
- stat_valid  out  1  one-cycle pulse at packet end
- stat_ovf_cnt, stat_udf_cnt  out  16 each  beats in packet with any lane overflow / underflow
- stat_min_res  out  6  minimum dout_resolution within packet

## Operation
- Stage 1: compute shift; sign-extend each lane to INPUT_WIDTH+MAX_SHIFT+1 bits and shift left. Shift outside 0..MAX_SHIFT: lanes zeroed, exp_invalid set.
- Stage 2: output lane = bits [OUT_LSB+OUTPUT_WIDTH−1 : OUT_LSB]. Overflow = bits above output MSB not all equal to output MSB. Underflow = any nonzero bit below OUT_LSB (always 0 if OUT_LSB=0). Truncation, no rounding.
- Invalid exponent: data 0, all overflow/underflow bits 1, resolution 0.
- Resolution = min(shift+INPUT_WIDTH−1, OUT_LSB+OUTPUT_WIDTH−1) − max(shift, OUT_LSB) + 1, clamped to 0 when negative.
- EXP_MODE=1: exponent register loads on accepted SOP beat. Non-SOP beats use the register. Register resets to EXP_REF.
- Statistics: counters and min tracker reload on each accepted output SOP beat, counting that beat. Counters saturate at 0xFFFF. On an accepted output EOP beat, stat_* load the final values and stat_valid pulses the next cycle. SOP+EOP on one beat is a one-beat packet. SOP without a prior EOP restarts the counters with no stat pulse.

## Timing
- Latency 2 cycles from accepted input to dout_valid when not stalled. Throughput 1 beat/cycle.
- Global enable en = dout_ready | ~dout_valid; din_ready = en (combinational). Both stages advance only when en is high.
- dout_* hold stable while dout_valid & ~dout_ready.
- Reset values: dout_valid 0, dout_sop/eop 0, dout_data 0, dout_error 0, overflow/underflow 0, exp_invalid 0, dout_resolution = min(INPUT_WIDTH, OUTPUT_WIDTH), stat_valid 0, stat_* counts 0, stat_min_res 63.
- Reset mid-packet drops in-flight beats and clears packet state; no stat pulse follows.

## Configuration
- UTIL_BFP_SCALER_SAT_EN defined: an overflowing lane outputs the saturated value (0x7FFF / 0x8000 for 16 bits, sign taken from the pre-truncation MSB). dout_overflow is still reported.
- Not defined: the output wraps (plain bit-select).

## Test plan
- exp=0, lane=0x1234, defaults → dout 0x1234, no overflow/underflow, resolution 16, 2-cycle latency.
- exp=4, lane=0x1234 → dout 0x0123, underflow=1, resolution 12.
- exp=−3, lane=0x1234 → overflow=1, resolution 13. Dout 0x91A0 without SAT_EN; 0x7FFF with SAT_EN.
- exp=5 → data 0, dout_exp_invalid=1, all flags 1, resolution 0.
- EXP_MODE=1, 4-beat packet with exp=0 on SOP and exp=−3 on later beats → all beats scaled by exp 0. Stat_valid pulse gives ovf_cnt 0, min_res 16.
- Random dout_ready toggling, 100 beats → no loss or duplication, outputs stable during stalls, stat counts match the model.
